// File: rtl/pulse_width_capture.sv
// Pulse high-time capture against an external microsecond timer, with a
// 2-flop input synchronizer and a five-state FSM. Define PWC_RANGE_CHECK_EN
// to reject widths outside [MIN_US, MAX_US].
module pulse_width_capture #(
    parameter logic [15:0] MIN_US = 16'd800,
    parameter logic [15:0] MAX_US = 16'd2200
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        En,
    input  logic        PwmIn,
    input  logic [15:0] Nus,
    input  logic        OVERFLW,
    output logic        TmrEn,
    output logic [15:0] Width,
    output logic        Valid,
    output logic        Err,
    output logic        Busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        ARMED,
        MEAS,
        DONE
    } state_t;

    state_t      state;
    logic        pwm_meta_p0;
    logic        pwm_sync_p1;
    logic        pwm_prev_p2;
    logic        rise_p3;
    logic        fall_p3;
    logic [15:0] cap_width;

    function automatic logic in_range(input logic [15:0] w);
        return (w >= MIN_US) && (w <= MAX_US);
    endfunction

    // Stages p0/p1: metastability synchronizer; p2: previous level; p3: registered edges
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_meta_p0 <= 1'b0;
            pwm_sync_p1 <= 1'b0;
            pwm_prev_p2 <= 1'b0;
            rise_p3     <= 1'b0;
            fall_p3     <= 1'b0;
        end else begin
            pwm_meta_p0 <= PwmIn;
            pwm_sync_p1 <= pwm_meta_p0;
            pwm_prev_p2 <= pwm_sync_p1;
            rise_p3     <= pwm_sync_p1 & ~pwm_prev_p2;
            fall_p3     <= ~pwm_sync_p1 & pwm_prev_p2;
        end
    end

    // Timer snapshot at the fall; only consumed in DONE, so it needs no reset
    always_ff @(posedge CLK) begin
        if (En && (state == MEAS) && fall_p3 && !OVERFLW) begin
            cap_width <= Nus;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            TmrEn <= 1'b0;
            Busy  <= 1'b0;
            Valid <= 1'b0;
            Err   <= 1'b0;
            Width <= 16'd0;
        end else begin
            Valid <= 1'b0;
            Err   <= 1'b0;
            if (!En) begin
                state <= IDLE;
                TmrEn <= 1'b0;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_LOW;
                    end
                    // A pulse already high at arming time must finish before we arm
                    WAIT_LOW: begin
                        if (!pwm_sync_p1) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (rise_p3) begin
                            state <= MEAS;
                            TmrEn <= 1'b1;
                            Busy  <= 1'b1;
                        end
                    end
                    // Overflow outranks a simultaneous fall
                    MEAS: begin
                        if (OVERFLW) begin
                            state <= WAIT_LOW;
                            TmrEn <= 1'b0;
                            Busy  <= 1'b0;
                            Err   <= 1'b1;
                        end else if (fall_p3) begin
                            state <= DONE;
                            TmrEn <= 1'b0;
                            Busy  <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= ARMED;
`ifdef PWC_RANGE_CHECK_EN
                        if (in_range(cap_width)) begin
                            Width <= cap_width;
                            Valid <= 1'b1;
                        end else begin
                            Err <= 1'b1;
                        end
`else
                        Width <= cap_width;
                        Valid <= 1'b1;
`endif
                    end
                    default: begin
                        state <= IDLE;
                        TmrEn <= 1'b0;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_capture.sv
// Scoreboard bench for pulse_width_capture with a behavioural us-timer model
// (one timer step per clock) and a width-outcome reference model.
module tb_pulse_width_capture;

    localparam int MIN_W = 800;
    localparam int MAX_W = 2200;

    logic        CLK;
    logic        RST;
    logic        En;
    logic        PwmIn;
    logic [15:0] Nus;
    logic        OVERFLW;
    logic        TmrEn;
    logic [15:0] Width;
    logic        Valid;
    logic        Err;
    logic        Busy;

    typedef struct {
        bit is_err;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   last_lo = 0;
    int   last_hi = 0;
    int   step = 1;

    logic [15:0] tmr_cnt;
    logic        tmr_ovf;

    pulse_width_capture dut (
        .CLK    (CLK),
        .RST    (RST),
        .En     (En),
        .PwmIn  (PwmIn),
        .Nus    (Nus),
        .OVERFLW(OVERFLW),
        .TmrEn  (TmrEn),
        .Width  (Width),
        .Valid  (Valid),
        .Err    (Err),
        .Busy   (Busy)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // Upstream 16-bit us timer: held clear while TmrEn is low, carry gives OVERFLW
    always @(posedge CLK) begin
        if (!TmrEn) begin
            tmr_cnt <= 16'd0;
            tmr_ovf <= 1'b0;
        end else begin
            {tmr_ovf, tmr_cnt} <= {1'b0, tmr_cnt} + 17'(step);
        end
    end
    assign Nus     = tmr_cnt;
    assign OVERFLW = tmr_ovf;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference outcome of one pulse of w_us microseconds
    task automatic model_pulse(input int w_us);
        exp_t e;
        bit   reject;
        reject = (w_us >= 65536);
`ifdef PWC_RANGE_CHECK_EN
        if (w_us < MIN_W || w_us > MAX_W) reject = 1'b1;
`endif
        if (reject) begin
            e.is_err = 1'b1;
            e.lo = last_lo;
            e.hi = last_hi;
        end else begin
            e.is_err = 1'b0;
            e.lo = w_us - 1;
            e.hi = w_us + 1;
            last_lo = e.lo;
            last_hi = e.hi;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe pops one expected outcome
    always @(negedge CLK) begin
        if (!RST && (Valid || Err)) begin
            exp_t e;
            tests++;
            if (Valid && Err) begin
                fails++;
                $display("FAIL strobe_excl: Valid=%0b Err=%0b both high", Valid, Err);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: Valid=%0b Err=%0b Width=%0d, expected none",
                         Valid, Err, Width);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err != Err) begin
                    fails++;
                    $display("FAIL strobe_kind: Err=%0b, expected Err=%0b", Err, e.is_err);
                end else if (int'(Width) < e.lo || int'(Width) > e.hi) begin
                    fails++;
                    $display("FAIL width: got %0d, expected %0d..%0d", Width, e.lo, e.hi);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        check({name, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // High pulse of w clocks (= w us); returns TmrEn-high cycles observed
    task automatic pulse(input int w, input bit expect_evt, output int ton);
        ton = 0;
        if (expect_evt) model_pulse(w * step);
        @(posedge CLK);
        #2 PwmIn = 1'b1;
        repeat (w) begin
            @(negedge CLK);
            ton += int'(TmrEn);
        end
        @(posedge CLK);
        #2 PwmIn = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            ton += int'(TmrEn);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ton;
        int w;
        int k;
        bit seen;

        RST = 1'b1;
        En = 1'b0;
        PwmIn = 1'b0;
        cyc(3);
        @(negedge CLK);
        check("rst_TmrEn", TmrEn, 0);
        check("rst_Width", Width, 0);
        check("rst_Valid", Valid, 0);
        check("rst_Err", Err, 0);
        check("rst_Busy", Busy, 0);
        cyc(1);
        RST = 1'b0;

        // Basic 1500 us pulse
        En = 1'b1;
        cyc(10);
        @(negedge CLK);
        check("idle_TmrEn", TmrEn, 0);
        pulse(1500, 1'b1, ton);
        check_rng("p1500_TmrEn_cycles", ton, 1499, 1501);
        check("p1500_after_Busy", Busy, 0);
        drain("p1500", 30);

        // Pulse already high at enable is ignored
        En = 1'b0;
        cyc(3);
        PwmIn = 1'b1;
        cyc(2);
        En = 1'b1;
        cyc(40);
        @(negedge CLK);
        check("prehigh_TmrEn", TmrEn, 0);
        cyc(1);
        PwmIn = 1'b0;
        cyc(10);
        pulse(1200, 1'b1, ton);
        check_rng("p1200_TmrEn_cycles", ton, 1199, 1201);
        drain("p1200", 30);

        // Random widths, kept clear of the +/-1 band around the range limits
        for (int i = 0; i < 4; i++) begin
            w = int'($urandom_range(900, 3000));
            if ((w >= MIN_W - 2 && w <= MIN_W + 2) || (w >= MAX_W - 2 && w <= MAX_W + 2)) w += 5;
            pulse(w, 1'b1, ton);
            drain("rand", 30);
            cyc(int'($urandom_range(5, 40)));
        end

        // 500 us: rejected only with range checking
        pulse(500, 1'b1, ton);
        drain("p500", 30);

        // Timer overflow: a 70 ms pulse with the timer stepping 16 us per clock
        step = 16;
        model_pulse(70000);
        @(posedge CLK);
        #2 PwmIn = 1'b1;
        seen = 1'b0;
        k = 0;
        for (int c = 1; c <= 4375; c++) begin
            @(negedge CLK);
            if (Err && !seen) begin
                seen = 1'b1;
                k = c;
            end
            if (c == 2000) check("ovf_mid_Busy", Busy, 1);
        end
        check("ovf_err_seen", int'(seen), 1);
        check_rng("ovf_err_delay", k, 4090, 4115);
        check("ovf_TmrEn_dropped", TmrEn, 0);
        @(posedge CLK);
        #2 PwmIn = 1'b0;
        drain("ovf", 30);
        step = 1;
        cyc(10);
        pulse(1000, 1'b1, ton);
        drain("p1000", 30);

        // En dropped 300 us into a pulse
        @(posedge CLK);
        #2 PwmIn = 1'b1;
        cyc(300);
        @(negedge CLK);
        check("endrop_pre_Busy", Busy, 1);
        @(posedge CLK);
        #2 En = 1'b0;
        cyc(2);
        @(negedge CLK);
        check("endrop_TmrEn", TmrEn, 0);
        check("endrop_Busy", Busy, 0);
        cyc(100);
        PwmIn = 1'b0;
        cyc(20);
        En = 1'b1;
        cyc(10);

        // Asynchronous reset mid-measurement
        @(posedge CLK);
        #2 PwmIn = 1'b1;
        cyc(200);
        @(negedge CLK);
        check("rstmid_pre_TmrEn", TmrEn, 1);
        @(posedge CLK);
        #5 RST = 1'b1;
        #1;
        check("rstmid_TmrEn", TmrEn, 0);
        check("rstmid_Width", Width, 0);
        check("rstmid_Valid", Valid, 0);
        check("rstmid_Err", Err, 0);
        check("rstmid_Busy", Busy, 0);
        last_lo = 0;
        last_hi = 0;
        PwmIn = 1'b0;
        cyc(5);
        RST = 1'b0;
        cyc(10);
        pulse(1800, 1'b1, ton);
        drain("p1800", 30);

        cyc(20);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_width_capture.md
PULSE_WIDTH_CAPTURE -- requirements
Module: pulse_width_capture

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- MIN_US, 16'd800, minimum accepted width in us.
- MAX_US, 16'd2200, maximum accepted width in us.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  reset, asynchronous, active-high.
- En  in  1  capture enable.
- PwmIn  in  1  asynchronous pulse input.
- Nus  in  16  elapsed us from the upstream 16-bit us timer.
- OVERFLW  in  1  overflow flag from the upstream us timer.
- TmrEn  out  1  enable to the us timer; its low level clears the timer.
- Width  out  16  last accepted high-time in us.
- Valid  out  1  one-cycle strobe; Width has been updated.
- Err  out  1  one-cycle strobe; measurement rejected.
- Busy  out  1  high while in MEAS.
REQ-003 The design SHALL use one clock, CLK. RST SHALL be asynchronous and active-high.

Function
REQ-004 PwmIn SHALL pass through a 2-flop synchronizer and then a registered edge detector; rise and fall SHALL be detected 3 CLK after the input edge.
REQ-005 The FSM SHALL have exactly five states: IDLE, WAIT_LOW, ARMED, MEAS, DONE.
REQ-006 FSM transitions SHALL be:
- IDLE -> WAIT_LOW when En=1.
- WAIT_LOW -> ARMED when the synchronized input is 0.
- ARMED -> MEAS on a detected rise.
- MEAS -> DONE on a detected fall.
- DONE -> ARMED unconditionally after 1 cycle.
REQ-007 A pulse already high when capture is armed SHALL be ignored; measurement SHALL start only on a subsequent rise.
REQ-008 TmrEn SHALL be 1 only in MEAS. It SHALL be registered and assert the cycle after the rise is detected.
REQ-009 On the fall, Nus SHALL be sampled as the width. The result SHALL be the true high-time +/-1 us, because the sync delay is equal on both edges.
REQ-010 In DONE the result SHALL be accepted and loaded into Width, with Valid=1 for exactly 1 cycle.
REQ-011 OVERFLW=1 while in MEAS SHALL cause:
- Err=1 for 1 cycle;
- TmrEn dropped;
- transition to WAIT_LOW;
- Width unchanged.
REQ-012 If a detected fall and OVERFLW=1 occur in the same cycle, overflow SHALL win and Err SHALL be raised.
REQ-013 En=0 in any state SHALL force IDLE on the next cycle, with TmrEn=0, no Valid or Err, and Width retained.
REQ-014 Valid and Err SHALL never be asserted in the same cycle.
REQ-015 Busy SHALL equal (state==MEAS), registered.
REQ-016 Width SHALL change only when Valid is asserted.

Reset
REQ-017 While RST=1, the FSM SHALL be held in IDLE, the synchronizer flops at 0, and TmrEn, Width, Valid, Err and Busy at 0.
REQ-018 RST asserted mid-MEAS SHALL clear all of the above immediately, with no strobe.
REQ-019 After RST is released, the first measurement SHALL require a full WAIT_LOW -> ARMED -> rise sequence.

Configuration
REQ-020 Range checking SHALL be controlled by the macro PWC_RANGE_CHECK_EN.
REQ-021 With PWC_RANGE_CHECK_EN defined, a width outside [MIN_US, MAX_US] SHALL produce Err in DONE instead of Valid, and Width SHALL remain unchanged.
REQ-022 Without PWC_RANGE_CHECK_EN, every non-overflow width SHALL be accepted with Valid, and MIN_US and MAX_US SHALL be unused.

Verification
REQ-023 En=1, PwmIn low, then a 1500 us high pulse -> Valid one cycle, Width=1500+/-1, Err=0, TmrEn high only during the pulse.
REQ-024 PwmIn already high when En rises, then low, then a 1200 us pulse -> the first pulse is ignored and Width=1200+/-1.
REQ-025 A 70 ms high pulse -> Err one cycle about 65.536 ms after the rise, Width retains its previous value, and the next 1000 us pulse gives Width=1000+/-1.
REQ-026 A 500 us pulse with PWC_RANGE_CHECK_EN defined -> Err and Width unchanged; the same pulse without the macro -> Valid and Width=500+/-1.
REQ-027 En dropped 300 us into a pulse -> TmrEn=0 within 2 cycles, no Valid and no Err, Busy=0.
REQ-028 RST=1 pulsed mid-MEAS -> all outputs 0 asynchronously; after release, a 1800 us pulse gives Width=1800+/-1.
